// File: rtl/alb_seq_ctrl_if.sv
// alb_seq_ctrl_if: wide request / result bundle between datapath
// control (master) and the multi-nibble ALB sequencer (slave).
interface alb_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         co;
    logic         vo;
    logic         no;
    logic         zo;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, co, vo, no, zo
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, co, vo, no, zo
    );
endinterface

// File: rtl/alb_seq_ctrl.sv
// alb_seq_ctrl: issues one wide op to a 4-bit ALB nibble by nibble, LS first.
// Optional abort input enabled by defining ALB_SEQ_ABORT_EN.
module alb_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ALB_SEQ_ABORT_EN
    input  logic       abort,
`endif
    alb_seq_ctrl_if.slave bus,
    output logic [3:0] alb_r,
    output logic [3:0] alb_s,
    output logic       alb_ci,
    output logic [1:0] alb_i,
    input  logic [3:0] alb_f,
    input  logic       alb_co,
    input  logic       alb_vo,
    input  logic       alb_no,
    input  logic       alb_zo
);
    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] K_LAST = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t       r_state;
    logic [2:0]   r_k;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [1:0]   r_op;
    logic         r_cin;
    logic [W-5:0] r_acc;
    logic         r_zacc;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_result;
    logic         r_co;
    logic         r_vo;
    logic         r_no;
    logic         r_zo;
    logic [W-1:0] w_acc_sh;
    logic         w_ci;
    logic         w_issue;

    // Slices arrive one cycle late from the ALB; shift them in at the top.
    assign w_acc_sh = {alb_f, r_acc};
    assign w_issue  = (r_state == S_ISSUE);

    always_comb begin
        w_ci = 1'b0;
        if (w_issue) begin
            if (r_k == 3'd0) begin
                w_ci = r_cin;
            end else begin
                unique case (r_op)
                    2'b10:   w_ci = alb_co;
                    2'b00:   w_ci = ~alb_co;
                    default: w_ci = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cin    <= 1'b0;
            r_acc    <= '0;
            r_zacc   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_vo     <= 1'b0;
            r_no     <= 1'b0;
            r_zo     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_cin   <= bus.cin;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_zacc  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_a <= r_a >> 4;
                    r_b <= r_b >> 4;
                    r_k <= r_k + 3'd1;
                    if (r_k != 3'd0) begin
                        r_acc  <= w_acc_sh[W-1:4];
                        r_zacc <= r_zacc & alb_zo;
                    end
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_result <= w_acc_sh;
                    r_co     <= alb_co;
                    r_vo     <= alb_vo;
                    r_no     <= alb_no;
                    r_zo     <= r_zacc & alb_zo;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
`ifdef ALB_SEQ_ABORT_EN
            // Abort wins over the drain capture: results keep old values.
            if (abort && r_busy) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_result <= r_result;
                r_co     <= r_co;
                r_vo     <= r_vo;
                r_no     <= r_no;
                r_zo     <= r_zo;
            end
`endif
        end
    end

    assign alb_r  = w_issue ? r_a[3:0] : 4'd0;
    assign alb_s  = w_issue ? r_b[3:0] : 4'd0;
    assign alb_i  = w_issue ? r_op : 2'b00;
    assign alb_ci = w_ci;

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.co     = r_co;
    assign bus.vo     = r_vo;
    assign bus.no     = r_no;
    assign bus.zo     = r_zo;
endmodule
